// File: rtl/prog_loader.sv
// Program loader: streams 9-bit instruction words into instruction memory, holds the
// core in reset while loading, then runs it and records the cycle count to done.
// Optional run watchdog: define PROG_LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter int IW      = 9,
  parameter int AW      = 12,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_wdata,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic [CW-1:0] cycles,
  output logic [AW-1:0] word_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RELEASE,
    RUN,
    FINISH
  } state_t;

  state_t state, next_state;

  logic xfer;
  logic wc_max;
  logic clear;
  logic to_hit;

  assign in_ready   = (state == LOAD);
  assign xfer       = in_valid && in_ready;
  assign wc_max     = &word_count;
  assign clear      = start && ((state == IDLE) || (state == FINISH));
  assign core_reset = (state != RUN);
  assign busy       = (state == LOAD) || (state == RELEASE) || (state == RUN);
  assign finished   = (state == FINISH);

`ifdef PROG_LOADER_TIMEOUT_EN
  // core_done has priority over the watchdog when both land in the same cycle
  assign to_hit = (state == RUN) && !core_done && (cycles == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      timed_out <= 1'b0;
    end else if (clear) begin
      timed_out <= 1'b0;
    end else if (to_hit) begin
      timed_out <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign timed_out      = 1'b0;
  assign unused_timeout = ^(32'(TIMEOUT));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    if (xfer && (in_last || wc_max)) next_state = RELEASE;
      RELEASE: next_state = RUN;
      RUN:     if (core_done || to_hit) next_state = FINISH;
      FINISH:  if (start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      word_count <= '0;
      cycles     <= '0;
    end else begin
      im_we <= 1'b0;
      if (clear) begin
        word_count <= '0;
        cycles     <= '0;
      end
      // word_count sticks at the top address; the transfer there ends the load
      if (xfer) begin
        im_we    <= 1'b1;
        im_addr  <= word_count;
        im_wdata <= in_data;
        if (!wc_max) begin
          word_count <= word_count + 1'b1;
        end
      end
      if ((state == RUN) && !core_done && !to_hit && !(&cycles)) begin
        cycles <= cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboarded memory writes plus per-scenario
// checks of handshake, core reset sequencing, cycle counting and reset recovery.
module tb_prog_loader;

  localparam int IW = 9;
  localparam int AW = 12;
  localparam int CW = 16;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [IW-1:0] im_wdata;
  logic          core_reset;
  logic          core_done = 1'b0;
  logic          busy;
  logic          finished;
  logic          timed_out;
  logic [CW-1:0] cycles;
  logic [AW-1:0] word_count;

  prog_loader #(.IW(IW), .AW(AW), .CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .core_reset(core_reset), .core_done(core_done),
    .busy(busy), .finished(finished), .timed_out(timed_out),
    .cycles(cycles), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
  } wr_t;

  wr_t           q[$];
  logic [AW-1:0] exp_addr;
  int            compared = 0;
  int            mismatched = 0;

  // in_ready, im_we, im_addr, im_wdata, core_reset, busy, finished, timed_out, cycles, word_count
  localparam logic [54:0] RESET_SNAP = {1'b0, 1'b0, 12'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 12'h000};
  wire [54:0] snap = {in_ready, im_we, im_addr, im_wdata, core_reset, busy, finished, timed_out, cycles, word_count};

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write", im_addr, im_wdata);
      end else begin
        wr_t e;
        e = q.pop_front();
        if ({im_addr, im_wdata} !== e) begin
          mismatched++;
          $display("FAIL write: got addr=%0h data=%0h, expected addr=%0h data=%0h", im_addr, im_wdata, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load;
    start    = 1'b1;
    exp_addr = '0;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [IW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    q.push_back({exp_addr, d});
    exp_addr = exp_addr + 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    compared++;
    if (snap !== RESET_SNAP) begin
      mismatched++;
      $display("FAIL reset_state: got %h, expected %h", snap, RESET_SNAP);
    end
  endtask

  task automatic test_back_to_back;
    logic [IW-1:0] w [4];
    w = '{9'h1A0, 9'h0FF, 9'h123, 9'h000};
    start_load();
    compared++;
    if ({in_ready, busy, core_reset, finished} !== 4'b1110) begin
      mismatched++;
      $display("FAIL load_entry: got rdy/busy/crst/fin=%b, expected 1110", {in_ready, busy, core_reset, finished});
    end
    for (int i = 0; i < 4; i++) send_word(w[i], i == 3);
    compared++;
    if ({in_ready, core_reset, busy} !== 3'b011 || word_count !== 12'd4) begin
      mismatched++;
      $display("FAIL release_cycle: got rdy/crst/busy=%b wc=%0d, expected 011 wc=4", {in_ready, core_reset, busy}, word_count);
    end
    tick();
    compared++;
    if (core_reset !== 1'b0 || busy !== 1'b1 || q.size() != 0) begin
      mismatched++;
      $display("FAIL run_entry: got crst=%b busy=%b pending=%0d, expected crst=0 busy=1 pending=0", core_reset, busy, q.size());
    end
  endtask

  task automatic test_run_done;
    repeat (10) tick();
    compared++;
    if (cycles !== 16'd10) begin
      mismatched++;
      $display("FAIL run_count: got %0d, expected 10", cycles);
    end
    repeat (27) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    compared++;
    if ({finished, core_reset, busy} !== 3'b110 || cycles !== 16'd37) begin
      mismatched++;
      $display("FAIL run_done: got fin/crst/busy=%b cycles=%0d, expected 110 cycles=37", {finished, core_reset, busy}, cycles);
    end
    core_done = 1'b1;
    repeat (3) tick();
    core_done = 1'b0;
    compared++;
    if (finished !== 1'b1 || cycles !== 16'd37 || word_count !== 12'd4) begin
      mismatched++;
      $display("FAIL finish_hold: got fin=%b cycles=%0d wc=%0d, expected fin=1 cycles=37 wc=4", finished, cycles, word_count);
    end
  endtask

  task automatic test_gaps;
    logic [IW-1:0] w [3];
    w = '{9'h055, 9'h1AA, 9'h101};
    start_load();
    compared++;
    if ({finished, busy} !== 2'b01 || cycles !== '0 || word_count !== '0) begin
      mismatched++;
      $display("FAIL restart_clear: got fin=%b busy=%b cycles=%0d wc=%0d, expected fin=0 busy=1 cycles=0 wc=0", finished, busy, cycles, word_count);
    end
    for (int i = 0; i < 3; i++) begin
      send_word(w[i], i == 2);
      if (i < 2) begin
        start = (i == 0);
        tick();
        start = 1'b0;
        tick();
      end
    end
    compared++;
    if (word_count !== 12'd3 || in_ready !== 1'b0 || core_reset !== 1'b1) begin
      mismatched++;
      $display("FAIL gap_load: got wc=%0d rdy=%b crst=%b, expected wc=3 rdy=0 crst=1", word_count, in_ready, core_reset);
    end
    tick();
    repeat (5) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    compared++;
    if (finished !== 1'b1 || cycles !== 16'd5 || q.size() != 0) begin
      mismatched++;
      $display("FAIL gap_run: got fin=%b cycles=%0d pending=%0d, expected fin=1 cycles=5 pending=0", finished, cycles, q.size());
    end
  endtask

  task automatic test_reset_mid_load;
    start_load();
    send_word(9'h0C3, 1'b0);
    send_word(9'h13C, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if (snap !== RESET_SNAP || q.size() != 0) begin
      mismatched++;
      $display("FAIL mid_load_reset: got %h pending=%0d, expected %h pending=0", snap, q.size(), RESET_SNAP);
    end
    start_load();
    send_word(9'h1FF, 1'b1);
    compared++;
    if (word_count !== 12'd1) begin
      mismatched++;
      $display("FAIL reload_count: got %0d, expected 1", word_count);
    end
    tick();
    repeat (3) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    compared++;
    if (finished !== 1'b1 || cycles !== 16'd3 || q.size() != 0) begin
      mismatched++;
      $display("FAIL reload_run: got fin=%b cycles=%0d pending=%0d, expected fin=1 cycles=3 pending=0", finished, cycles, q.size());
    end
  endtask

  task automatic test_saturation;
    start_load();
    for (int i = 0; i < 4096; i++) send_word(9'(i) ^ 9'h05A, 1'b0);
    in_valid = 1'b1;
    in_data  = 9'h1EE;
    compared++;
    if ({in_ready, core_reset, busy} !== 3'b011) begin
      mismatched++;
      $display("FAIL sat_release: got rdy/crst/busy=%b, expected 011", {in_ready, core_reset, busy});
    end
    tick();
    in_valid = 1'b0;
    compared++;
    if (core_reset !== 1'b0 || q.size() != 0 || im_addr !== 12'hFFF) begin
      mismatched++;
      $display("FAIL sat_run: got crst=%b pending=%0d last_addr=%0h, expected crst=0 pending=0 last_addr=fff", core_reset, q.size(), im_addr);
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic test_timeout;
    start_load();
    send_word(9'h001, 1'b1);
    tick();
`ifdef PROG_LOADER_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (finished !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
    end
    compared++;
    if ({finished, timed_out, busy} !== 3'b110 || cycles !== 16'(TO)) begin
      mismatched++;
      $display("FAIL watchdog: got fin/to/busy=%b cycles=%0d, expected 110 cycles=%0d", {finished, timed_out, busy}, cycles, TO);
    end
`else
    repeat (200) tick();
    compared++;
    if ({finished, timed_out, busy} !== 3'b001 || cycles !== 16'd200) begin
      mismatched++;
      $display("FAIL no_watchdog: got fin/to/busy=%b cycles=%0d, expected 001 cycles=200", {finished, timed_out, busy}, cycles);
    end
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_run_done();
    test_gaps();
    test_reset_mid_load();
    test_saturation();
    test_timeout();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
